// File: rtl/game_round_sequencer.sv
// Round controller for the reaction game: IDLE -> START -> PLAY -> FINISH, paced by a 1 Hz tick enable.
// Tracks completed rounds and the best signed score; define GAME_PAUSE_EN to add a countdown-freezing pause input.
module game_round_sequencer #(
    parameter int PLAYERS      = 2,
    parameter int SCORE_W      = 11,
    parameter int START_TICKS  = 3,
    parameter int GAME_TICKS   = 30,
    parameter int FINISH_TICKS = 5,
    parameter int GAMES_W      = 4
) (
    input  logic                       clk,
    input  logic                       resetAll_n,
    input  logic                       tick_1hz,
    input  logic                       resetGame,
    input  logic                       go,
`ifdef GAME_PAUSE_EN
    input  logic                       pause,
`endif
    input  logic [PLAYERS*SCORE_W-1:0] score_in,
    output logic [1:0]                 state,
    output logic [7:0]                 countdown,
    output logic                       init_pulse,
    output logic                       round_done,
    output logic [GAMES_W-1:0]         games_played,
    output logic [SCORE_W-1:0]         high_score,
    output logic [2:0]                 high_player,
    output logic                       high_valid,
    output logic                       new_high
);

    generate
        if (PLAYERS < 1 || PLAYERS > 8) begin : g_bad_players
            $error("game_round_sequencer: PLAYERS must be 1..8");
        end
        if (START_TICKS < 1 || START_TICKS > 255) begin : g_bad_start
            $error("game_round_sequencer: START_TICKS must be 1..255");
        end
        if (GAME_TICKS < 1 || GAME_TICKS > 255) begin : g_bad_game
            $error("game_round_sequencer: GAME_TICKS must be 1..255");
        end
        if (FINISH_TICKS < 1 || FINISH_TICKS > 255) begin : g_bad_finish
            $error("game_round_sequencer: FINISH_TICKS must be 1..255");
        end
        if (SCORE_W < 2 || GAMES_W < 1) begin : g_bad_width
            $error("game_round_sequencer: SCORE_W must be >=2 and GAMES_W >=1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        START  = 2'b01,
        PLAY   = 2'b10,
        FINISH = 2'b11
    } state_t;

    state_t state_q;
    logic   run;

    assign state = state_q;

`ifdef GAME_PAUSE_EN
    // Pause only freezes the timed phases before the finish window.
    assign run = tick_1hz && !(pause && (state_q == START || state_q == PLAY));
`else
    assign run = tick_1hz;
`endif

    // Signed maximum across players; strict compare keeps the lowest index on ties.
    logic signed [SCORE_W-1:0] best_score;
    logic        [2:0]         best_idx;

    always_comb begin
        best_score = $signed(score_in[SCORE_W-1:0]);
        best_idx   = 3'd0;
        for (int p = 1; p < PLAYERS; p++) begin
            if ($signed(score_in[p*SCORE_W +: SCORE_W]) > best_score) begin
                best_score = $signed(score_in[p*SCORE_W +: SCORE_W]);
                best_idx   = 3'(p);
            end
        end
    end

    always_ff @(posedge clk or negedge resetAll_n) begin
        if (!resetAll_n) begin
            state_q      <= IDLE;
            countdown    <= 8'd0;
            init_pulse   <= 1'b0;
            round_done   <= 1'b0;
            games_played <= '0;
            high_score   <= '0;
            high_player  <= 3'd0;
            high_valid   <= 1'b0;
            new_high     <= 1'b0;
        end else begin
            init_pulse <= 1'b0;
            round_done <= 1'b0;
            new_high   <= 1'b0;
            if (resetGame) begin
                state_q    <= IDLE;
                countdown  <= 8'd0;
                init_pulse <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (go) begin
                            state_q    <= START;
                            countdown  <= 8'(START_TICKS);
                            init_pulse <= 1'b1;
                        end
                    end
                    START: begin
                        if (run) begin
                            if (countdown == 8'd1) begin
                                state_q    <= PLAY;
                                countdown  <= 8'(GAME_TICKS);
                                init_pulse <= 1'b1;
                            end else begin
                                countdown <= countdown - 8'd1;
                            end
                        end
                    end
                    PLAY: begin
                        if (run) begin
                            if (countdown == 8'd1) begin
                                state_q    <= FINISH;
                                countdown  <= 8'(FINISH_TICKS);
                                init_pulse <= 1'b1;
                                round_done <= 1'b1;
                                if (games_played != {GAMES_W{1'b1}})
                                    games_played <= games_played + 1'b1;
                                if (!high_valid || best_score > $signed(high_score)) begin
                                    high_score  <= best_score;
                                    high_player <= best_idx;
                                    high_valid  <= 1'b1;
                                    new_high    <= 1'b1;
                                end
                            end else begin
                                countdown <= countdown - 8'd1;
                            end
                        end
                    end
                    FINISH: begin
                        if (run) begin
                            if (countdown == 8'd1) begin
                                state_q    <= IDLE;
                                countdown  <= 8'd0;
                                init_pulse <= 1'b1;
                            end else begin
                                countdown <= countdown - 8'd1;
                            end
                        end
                    end
                    default: begin
                        state_q   <= IDLE;
                        countdown <= 8'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/game_round_sequencer.md
Name: game_round_sequencer

Overview:
Parametrised round controller for the reaction-game top level. It sequences IDLE/status, start countdown, play, and finish countdown using a single-cycle 1 Hz tick enable, not separate clocks. It tracks games played and the best signed score across PLAYERS channels. Outputs drive the display/LED mux: the current state, the remaining countdown, and the statistics.

Parameters:
PLAYERS, 2, number of score channels (1..8)
SCORE_W, 11, signed score width in two's complement
START_TICKS, 3, start-countdown length in ticks (1..255)
GAME_TICKS, 30, play-phase length in ticks (1..255)
FINISH_TICKS, 5, finish-phase length in ticks (1..255)
GAMES_W, 4, games_played counter width

Ports:
clk  in  1  system clock
resetAll_n  in  1  asynchronous active-low reset; clears everything
tick_1hz  in  1  one-clk-wide enable pulse, once per second
resetGame  in  1  synchronous abort to IDLE; statistics kept
go  in  1  start request, honoured only in IDLE
score_in  in  PLAYERS*SCORE_W  packed signed scores; player p at bits [p*SCORE_W +: SCORE_W]
state  out  2  00 IDLE, 01 START, 10 PLAY, 11 FINISH
countdown  out  8  ticks remaining in the current phase; 0 in IDLE
init_pulse  out  1  one-cycle pulse on the first cycle of any state entry
round_done  out  1  one-cycle pulse on the PLAY->FINISH transition
games_played  out  GAMES_W  completed rounds, saturating
high_score  out  SCORE_W  best signed score recorded
high_player  out  3  player index holding high_score
high_valid  out  1  high_score holds a recorded value
new_high  out  1  one-cycle pulse when high_score updates

Behaviour:
- Reset (resetAll_n low, async): state=IDLE, countdown=0, games_played=0, high_score=0, high_player=0, high_valid=0, and all pulses are 0.
- All other logic is registered on posedge clk. Outputs are registered. Transitions take effect the cycle after the triggering input.
- IDLE with go=1: go to START, countdown=START_TICKS.
- START or PLAY or FINISH: each tick_1hz decrements countdown.
- A tick with countdown==1 transitions instead of decrementing:
  - START->PLAY, countdown=GAME_TICKS
  - PLAY->FINISH, countdown=FINISH_TICKS
  - FINISH->IDLE, countdown=0
- Each phase therefore lasts exactly its TICKS count of ticks. A tick in the same cycle as entry is not counted.
- init_pulse is asserted in the cycle where the new state first appears on `state`. This includes re-entry to IDLE via resetGame.
- PLAY->FINISH side effects, all in the same cycle that FINISH appears:
  - round_done=1
  - games_played increments, saturating at 2^GAMES_W-1
  - score_in is sampled in the transition cycle
  - the signed maximum across players is selected; ties go to the lowest index
  - if high_valid==0, or the maximum is strictly greater than high_score (signed compare): load high_score and high_player, set high_valid=1, pulse new_high
  - equal scores do not update
- resetGame=1 (sync) has highest priority. Same cycle as go or tick: state=IDLE, countdown=0, init_pulse next cycle. No statistics change. A round aborted in PLAY is not counted. resetGame while already in IDLE still pulses init_pulse.
- go outside IDLE is ignored. go held high re-starts only after the FINISH->IDLE transition has completed (IDLE lasts at least one cycle).
- Ticks in IDLE are ignored.
- Parameter legality (TICKS ≥1, PLAYERS ≤8) is checked at elaboration. An illegal value stops elaboration with an error.

Optional Feature:
GAME_PAUSE_EN
- When defined: adds input `pause` (1 bit). While pause=1 in START or PLAY, ticks are ignored and the countdown freezes. pause has no effect in FINISH or IDLE. resetGame still overrides pause.
- When undefined: the port is absent and countdowns always run.

Test Plan:
- Reset, then go, then 3+30+5 ticks spaced 10 clk, PLAYERS=2 with scores {p0=12, p1=-4}. Require:
  - state sequence 00->01->10->11->00
  - countdown 3,2,1 in START
  - games_played=1, high_score=12, high_player=0, new_high one pulse
- Second round with scores {5, 20}: high_score=20, high_player=1. Third round with {20, 20}: no update, no new_high pulse, games_played=3.
- First round with scores {-7, -9}: high_valid 0->1, high_score=-7 (0x7F9 at SCORE_W=11).
- resetGame asserted in PLAY at countdown=17, same cycle as a tick: state=IDLE, countdown=0, init_pulse once, games_played unchanged.
- GAMES_W=2, run 5 rounds: games_played=3 (saturated). Then resetAll_n low mid-START: all outputs 0 asynchronously, before the next clk edge.
- GAME_PAUSE_EN defined: pause=1 for 4 ticks in PLAY at countdown=10. Countdown holds 10 during pause, then resumes 9,8,…
